reg_write_arbiter: RTL and testbench

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_write_arbiter_pkg.sv | 20 ++
 rtl/reg_write_arbiter_if.sv | 30 +++
 rtl/reg_write_arbiter_rr_arbiter2.sv | 23 ++
 rtl/reg_write_arbiter.sv | 132 +++++++++++++
 tb/tb_reg_write_arbiter.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_write_arbiter_pkg.sv
// Shared definitions for the register writeback arbiter: default widths,
// architectural register count and requester identities.
package reg_write_arbiter_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int IDX_W_DEF  = 5;
   localparam int NUM_REGS   = 32;
   localparam int CNT_W      = 6;

   // Requester positions inside the valid/grant vectors
   localparam int REQ_A = 0;   // ALU writeback
   localparam int REQ_B = 1;   // load writeback

   // Identity of the requester that won the most recent transfer
   typedef enum logic {
      GRANT_A = 1'b0,
      GRANT_B = 1'b1
   } req_id_e;

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Writeback request channels (ALU = requester 0, load = requester 1).
// The arbiter is the slave side; the producers drive the master side.
interface reg_write_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int IDX_W  = 5
) ();

   logic              a_valid_in;
   logic [IDX_W-1:0]  a_idx_in;
   logic [DATA_W-1:0] a_data_in;
   logic              a_ready_out;

   logic              b_valid_in;
   logic [IDX_W-1:0]  b_idx_in;
   logic [DATA_W-1:0] b_data_in;
   logic              b_ready_out;

   modport master (
      output a_valid_in, a_idx_in, a_data_in,
      output b_valid_in, b_idx_in, b_data_in,
      input  a_ready_out, b_ready_out
   );

   modport slave (
      input  a_valid_in, a_idx_in, a_data_in,
      input  b_valid_in, b_idx_in, b_data_in,
      output a_ready_out, b_ready_out
   );

endinterface

// File: rtl/reg_write_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins; on contention
// the requester that did not win last time is granted.
module rr_arbiter2
   import reg_write_arbiter_pkg::*;
(
   input  logic [1:0] valid_in,
   input  req_id_e    last_grant_in,
   output logic [1:0] grant_out
);

   // One-hot grant from the current valids and the previous winner
   always_comb begin
      grant_out = valid_in;
      if (valid_in[REQ_A] && valid_in[REQ_B]) begin
         if (last_grant_in == GRANT_A) begin
            grant_out = 2'b10;
         end else begin
            grant_out = 2'b01;
         end
      end
   end

endmodule

// File: rtl/reg_write_arbiter.sv
// Register file write-port arbiter with a busy-bit scoreboard.
// Two writeback sources share one write port through a round-robin
// arbiter; issued destinations are marked busy until written back, and
// decode is stalled while a source operand is still pending.
module reg_write_arbiter
   import reg_write_arbiter_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int IDX_W  = IDX_W_DEF
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   reg_write_arbiter_if.slave wb,
   input  logic              issue_e_in,
   input  logic [IDX_W-1:0]  issue_idx_in,
   input  logic              rs1_e_in,
   input  logic [IDX_W-1:0]  rs1_idx_in,
   input  logic              rs2_e_in,
   input  logic [IDX_W-1:0]  rs2_idx_in,
   input  logic              flush_in,
   output logic              writeE_out,
   output logic [IDX_W-1:0]  writeIdx_out,
   output logic [DATA_W-1:0] writeData_out,
   output logic              stall_out,
   output logic [CNT_W-1:0]  busy_cnt_out
);

   logic [1:0]          valid_vec;
   logic [1:0]          grant_vec;
   logic [1:0]          ready_vec;
   logic                xfer_any;
   logic                xfer_live;
   logic                set_live;
   logic                cnt_inc;
   logic                cnt_dec;
   logic [IDX_W-1:0]    xfer_idx;
   logic [DATA_W-1:0]   xfer_data;

   req_id_e             last_grant_q, last_grant_d;
   logic                write_e_q, write_e_d;
   logic [IDX_W-1:0]    write_idx_q, write_idx_d;
   logic [DATA_W-1:0]   write_data_q, write_data_d;
   logic [NUM_REGS-1:0] busy_q, busy_d;
   logic [CNT_W-1:0]    busy_cnt_q, busy_cnt_d;

   assign valid_vec = {wb.b_valid_in, wb.a_valid_in};

   rr_arbiter2 u_rr_arbiter2 (
      .valid_in      (valid_vec),
      .last_grant_in (last_grant_q),
      .grant_out     (grant_vec)
   );

   // Readies are the grant, suppressed during flush and while held in reset
   always_comb begin
      ready_vec = grant_vec & {2{~flush_in & rst_n_in}};
      xfer_any  = |(ready_vec & valid_vec);
      xfer_idx  = ready_vec[REQ_B] ? wb.b_idx_in  : wb.a_idx_in;
      xfer_data = ready_vec[REQ_B] ? wb.b_data_in : wb.a_data_in;
      xfer_live = xfer_any && (xfer_idx != '0);
      set_live  = issue_e_in && (issue_idx_in != '0) && !flush_in;
   end

   assign wb.a_ready_out = ready_vec[REQ_A];
   assign wb.b_ready_out = ready_vec[REQ_B];

   // Next-state for grant history, write port and busy scoreboard
   always_comb begin
      last_grant_d = last_grant_q;
      write_e_d    = xfer_live;
      write_idx_d  = write_idx_q;
      write_data_d = write_data_q;
      busy_d       = busy_q;
      cnt_inc      = 1'b0;
      cnt_dec      = 1'b0;
      busy_cnt_d   = busy_cnt_q;

      if (xfer_any) begin
         last_grant_d = ready_vec[REQ_B] ? GRANT_B : GRANT_A;
         write_idx_d  = xfer_idx;
         write_data_d = xfer_data;
      end

      // Clear first so a same-index issue (new producer) wins
      if (xfer_live) begin
         busy_d[xfer_idx] = 1'b0;
      end
      if (set_live) begin
         busy_d[issue_idx_in] = 1'b1;
      end

      // Count follows the bits that actually flip
      cnt_inc = set_live && !busy_q[issue_idx_in];
      cnt_dec = xfer_live && busy_q[xfer_idx]
                && !(set_live && (issue_idx_in == xfer_idx));
      busy_cnt_d = busy_cnt_q + {{(CNT_W-1){1'b0}}, cnt_inc}
                              - {{(CNT_W-1){1'b0}}, cnt_dec};

      if (flush_in) begin
         busy_d     = '0;
         busy_cnt_d = '0;
      end
      busy_d[0] = 1'b0;
   end

   // State registers; reset makes requester 0 win the first contention
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         last_grant_q <= GRANT_B;
         write_e_q    <= 1'b0;
         write_idx_q  <= '0;
         write_data_q <= '0;
         busy_q       <= '0;
         busy_cnt_q   <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         write_e_q    <= write_e_d;
         write_idx_q  <= write_idx_d;
         write_data_q <= write_data_d;
         busy_q       <= busy_d;
         busy_cnt_q   <= busy_cnt_d;
      end
   end

   assign writeE_out    = write_e_q;
   assign writeIdx_out  = write_idx_q;
   assign writeData_out = write_data_q;
   assign busy_cnt_out  = busy_cnt_q;
   assign stall_out     = (rs1_e_in && busy_q[rs1_idx_in])
                       || (rs2_e_in && busy_q[rs2_idx_in]);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios followed
// by random traffic, checked against a behavioural model with a write
// scoreboard drained by an independent monitor.
module tb_reg_write_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   reg_write_arbiter_if #(.DATA_W(32), .IDX_W(5)) wb ();

   logic        issue_e = 1'b0;
   logic [4:0]  issue_idx = '0;
   logic        rs1_e = 1'b0;
   logic [4:0]  rs1_idx = '0;
   logic        rs2_e = 1'b0;
   logic [4:0]  rs2_idx = '0;
   logic        flush = 1'b0;
   logic        write_e;
   logic [4:0]  write_idx;
   logic [31:0] write_data;
   logic        stall;
   logic [5:0]  busy_cnt;

   reg_write_arbiter #(.DATA_W(32), .IDX_W(5)) dut (
      .clk_in        (clk),
      .rst_n_in      (rst_n),
      .wb            (wb),
      .issue_e_in    (issue_e),
      .issue_idx_in  (issue_idx),
      .rs1_e_in      (rs1_e),
      .rs1_idx_in    (rs1_idx),
      .rs2_e_in      (rs2_e),
      .rs2_idx_in    (rs2_idx),
      .flush_in      (flush),
      .writeE_out    (write_e),
      .writeIdx_out  (write_idx),
      .writeData_out (write_data),
      .stall_out     (stall),
      .busy_cnt_out  (busy_cnt)
   );

   typedef struct {
      int unsigned cyc;
      logic [4:0]  idx;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_q[$];
   wr_t         mon_e;
   int          grant_log[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int unsigned edge_cnt = 0;
   bit          m_busy[32];
   int          m_last = 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int m_count();
      int c = 0;
      for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
      return c;
   endfunction

   // One clock cycle of stimulus; model grant and scoreboard update at the edge
   task automatic step(input bit av, input int ai, input logic [31:0] ad,
                       input bit bv, input int bi, input logic [31:0] bd,
                       input bit iss, input int ii,
                       input bit r1e, input int r1, input bit r2e, input int r2,
                       input bit fl);
      bit ra, rb;
      int xi;
      logic [31:0] xd;
      @(negedge clk);
      wb.a_valid_in = av; wb.a_idx_in = 5'(ai); wb.a_data_in = ad;
      wb.b_valid_in = bv; wb.b_idx_in = 5'(bi); wb.b_data_in = bd;
      issue_e = iss; issue_idx = 5'(ii);
      rs1_e = r1e; rs1_idx = 5'(r1); rs2_e = r2e; rs2_idx = 5'(r2);
      flush = fl;
      ra = 1'b0;
      rb = 1'b0;
      if (!fl) begin
         if (av && bv) begin
            if (m_last == 1) ra = 1'b1; else rb = 1'b1;
         end else begin
            ra = av;
            rb = bv;
         end
      end
      #1;
      chk("a_ready", 64'(wb.a_ready_out), 64'(ra));
      chk("b_ready", 64'(wb.b_ready_out), 64'(rb));
      chk("stall", 64'(stall), 64'((r1e && m_busy[r1]) || (r2e && m_busy[r2])));
      chk("busy_cnt", 64'(busy_cnt), 64'(m_count()));
      @(posedge clk);
      edge_cnt++;
      if (ra || rb) begin
         xi = ra ? ai : bi;
         xd = ra ? ad : bd;
         m_last = ra ? 0 : 1;
         grant_log.push_back(m_last);
         if (xi != 0) begin
            exp_q.push_back('{edge_cnt, 5'(xi), xd});
            m_busy[xi] = 1'b0;
         end
      end
      if (fl) begin
         for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end else if (iss && ii != 0) begin
         m_busy[ii] = 1'b1;
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Asynchronous reset mid-cycle: outputs must drop at once, requests ignored
   task automatic apply_reset();
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      m_last = 1;
      wb.a_valid_in = 1'b1; wb.a_idx_in = 5'd9;  wb.a_data_in = 32'h1111_1111;
      wb.b_valid_in = 1'b1; wb.b_idx_in = 5'd10; wb.b_data_in = 32'h2222_2222;
      #1;
      chk("rst_write_e", 64'(write_e), 64'(0));
      chk("rst_write_idx", 64'(write_idx), 64'(0));
      chk("rst_write_data", 64'(write_data), 64'(0));
      chk("rst_busy_cnt", 64'(busy_cnt), 64'(0));
      chk("rst_a_ready", 64'(wb.a_ready_out), 64'(0));
      chk("rst_b_ready", 64'(wb.b_ready_out), 64'(0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_hold_busy_cnt", 64'(busy_cnt), 64'(0));
      wb.a_valid_in = 1'b0;
      wb.b_valid_in = 1'b0;
      rst_n = 1'b1;
   endtask

   // Monitor: every presented write must match the oldest expected one
   initial begin
      forever begin
         @(negedge clk);
         if (write_e === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_write: actual writeE=1 idx=%0d required writeE=0", write_idx);
            end else begin
               mon_e = exp_q.pop_front();
               chk("write_cycle", 64'(edge_cnt), 64'(mon_e.cyc));
               chk("write_idx", 64'(write_idx), 64'(mon_e.idx));
               chk("write_data", 64'(write_data), 64'(mon_e.data));
               $display("write  x%0d <= %08h", write_idx, write_data);
            end
         end else if (exp_q.size() > 0 && exp_q[0].cyc <= edge_cnt) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missing_write: actual writeE=%b required writeE=1 idx=%0d", write_e, exp_q[0].idx);
            void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      wb.a_valid_in = 1'b0; wb.a_idx_in = '0; wb.a_data_in = '0;
      wb.b_valid_in = 1'b0; wb.b_idx_in = '0; wb.b_data_in = '0;
      #1;
      chk("por_write_e", 64'(write_e), 64'(0));
      chk("por_busy_cnt", 64'(busy_cnt), 64'(0));
      @(posedge clk);
      apply_reset();

      // Single ALU write to x3, one-cycle latency
      step(1, 3, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(1);

      // Contention from reset alternates a, b, a, b
      @(posedge clk);
      apply_reset();
      grant_log.delete();
      for (int k = 0; k < 4; k++) step(1, 10 + k, 32'hA000_0000 + k, 1, 20 + k, 32'hB000_0000 + k,
                                       0, 0, 0, 0, 0, 0, 0);
      chk("alt_grant_count", 64'(grant_log.size()), 64'(4));
      for (int k = 0; k < 4 && k < grant_log.size(); k++)
         chk($sformatf("alt_grant_%0d", k), 64'(grant_log[k]), 64'(k % 2));
      idle(1);

      // Pending x5 stalls rs1 until the load writes it back
      step(0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0);
      chk("x5_stall", 64'(stall), 64'(1));
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 1, 1, 0);
      step(0, 0, 0, 1, 5, 32'h5555_0005, 0, 0, 1, 5, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0);
      chk("x5_released_cnt", 64'(busy_cnt), 64'(0));

      // Issue x7 in the same cycle its old value is written back
      step(0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0);
      step(1, 7, 32'h7777_0007, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0);
      chk("x7_still_busy", 64'(stall), 64'(1));
      chk("x7_cnt", 64'(busy_cnt), 64'(1));

      // Busy 2,4,6 then flush with a request and an issue present
      step(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0, 0);
      step(1, 2, 32'h0202_0202, 0, 0, 0, 1, 9, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 1, 4, 0);
      chk("flush_cnt", 64'(busy_cnt), 64'(0));
      chk("flush_write_e", 64'(write_e), 64'(0));

      // Write to x0 is accepted but never reaches the register file
      step(0, 0, 0, 0, 0, 0, 1, 8, 0, 0, 0, 0, 0);
      step(1, 0, 32'hCAFE_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("x0_write_e", 64'(write_e), 64'(0));
      chk("x0_cnt", 64'(busy_cnt), 64'(1));

      // Reset asserted while a write is pending discards it
      step(1, 12, 32'h1212_1212, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      apply_reset();
      idle(1);

      // Random traffic
      for (int k = 0; k < 400; k++) begin
         step($urandom_range(0, 1), $urandom_range(0, 9), $urandom,
              $urandom_range(0, 1), $urandom_range(0, 9), $urandom,
              $urandom_range(0, 2) == 0, $urandom_range(0, 9),
              $urandom_range(0, 1), $urandom_range(0, 9),
              $urandom_range(0, 1), $urandom_range(0, 9),
              $urandom_range(0, 19) == 0);
      end
      idle(2);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
